// File: rtl/response_resolver.sv
// Multiple-response resolver: captures a match vector and presents each set
// word one at a time, lowest index first, with a valid/next handshake.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   match_lines      per-word match vector (sampled only on load)
//   load             capture match_lines and start resolution
//   next             consumer accepts the presented responder
//   clear            abort resolution and empty the tags
//   resp_valid       a responder is presented
//   resp_index       index of the presented responder
//   resp_select      one-hot word enable of the responder (0 when not valid)
//   some_responder   tag register non-zero
//   resp_count       responders not yet accepted
//   done             resolution finished, nothing left
module response_resolver #(
  parameter int WORDS = 64,
  parameter int IDXW  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WORDS-1:0] match_lines,
  input  logic             load,
  input  logic             next,
  input  logic             clear,
  output logic             resp_valid,
  output logic [IDXW-1:0]  resp_index,
  output logic [WORDS-1:0] resp_select,
  output logic             some_responder,
  output logic [IDXW:0]    resp_count,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    PRESENT,
    DONE
  } state_t;

  localparam logic [WORDS-1:0] ONE = WORDS'(1);

  state_t           state;
  state_t           state_nx;
  logic [WORDS-1:0] tags;
  logic [IDXW-1:0]  lo_idx;
  logic [IDXW:0]    ld_count;
  logic             accept;

  // Lowest set tag: scan downward so the smallest index is written last.
  always_comb begin
    lo_idx = '0;
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (tags[i]) lo_idx = IDXW'(i);
    end
  end

  always_comb begin
    ld_count = '0;
    for (int i = 0; i < WORDS; i++) begin
      ld_count = ld_count + (IDXW+1)'(match_lines[i]);
    end
  end

  assign resp_valid     = (state == PRESENT);
  assign done           = (state == DONE);
  assign some_responder = |tags;
  assign resp_select    = resp_valid ? (ONE << resp_index) : '0;
  assign accept         = resp_valid && next;

  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = IDLE;
    end else if (load) begin
      state_nx = SCAN;
    end else begin
      unique case (state)
        SCAN:    state_nx = (|tags) ? PRESENT : DONE;
        PRESENT: if (next) state_nx = SCAN;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tags       <= '0;
      resp_count <= '0;
      resp_index <= '0;
    end else if (clear) begin
      tags       <= '0;
      resp_count <= '0;
      resp_index <= '0;
    end else if (load) begin
      tags       <= match_lines;
      resp_count <= ld_count;
      resp_index <= '0;
    end else if (state == SCAN && (|tags)) begin
      resp_index <= lo_idx;
    end else if (accept) begin
      tags <= tags & ~resp_select;
      if (resp_count != '0) resp_count <= resp_count - 1'b1;
    end
  end

endmodule

// File: tb/tb_response_resolver.sv
// Directed bench for response_resolver with a scoreboard of expected
// responders checked at each acceptance.
module tb_response_resolver;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] match_lines;
  logic        load;
  logic        next;
  logic        clear;
  logic        resp_valid;
  logic [5:0]  resp_index;
  logic [63:0] resp_select;
  logic        some_responder;
  logic [6:0]  resp_count;
  logic        done;

  response_resolver #(.WORDS(64), .IDXW(6)) dut (
    .clk(clk),
    .rst(rst),
    .match_lines(match_lines),
    .load(load),
    .next(next),
    .clear(clear),
    .resp_valid(resp_valid),
    .resp_index(resp_index),
    .resp_select(resp_select),
    .some_responder(some_responder),
    .resp_count(resp_count),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   pulses[$];
  int   c0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int idx, input int cnt);
    exp_t e;
    e.idx = idx;
    e.cnt = cnt;
    sb.push_back(e);
  endtask

  // One clock: if this edge accepts a responder, pop and compare first.
  task automatic cycle();
    exp_t e;
    logic [63:0] one;
    one = 64'd1;
    if (resp_valid && next && !load && !clear) begin
      if (sb.size() == 0) begin
        check("sb_underrun", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("acc_idx", 64'(resp_index), 64'(e.idx));
        check("acc_sel", resp_select, one << e.idx);
        check("acc_cnt", 64'(resp_count), 64'(e.cnt));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [63:0] outs();
    return {resp_valid, done, some_responder,
            resp_count, resp_index};
  endfunction

  initial begin
    rst = 1'b1;
    match_lines = '0;
    load = 1'b0;
    next = 1'b0;
    clear = 1'b0;
    #2;
    check("rst_outs", outs(), 64'd0);
    check("rst_sel", resp_select, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();

    // Empty match: SCAN then DONE, never valid.
    load = 1'b1;
    match_lines = 64'h0;
    cycle();
    load = 1'b0;
    check("empty_scan_valid", 64'(resp_valid), 64'd0);
    check("empty_scan_done", 64'(done), 64'd0);
    cycle();
    check("empty_done", 64'(done), 64'd1);
    check("empty_cnt", 64'(resp_count), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("empty_hold", {62'd0, resp_valid, done}, 64'd1);
    end

    // Three responders, next held high.
    push(0, 3);
    push(9, 2);
    push(63, 1);
    next = 1'b1;
    load = 1'b1;
    match_lines = 64'h8000_0000_0000_0201;
    c0 = cyc;
    cycle();
    load = 1'b0;
    match_lines = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      if (resp_valid) pulses.push_back(cyc);
      cycle();
    end
    next = 1'b0;
    check("three_done", 64'(done), 64'd1);
    check("three_cnt", 64'(resp_count), 64'd0);
    check("three_sb", 64'(sb.size()), 64'd0);
    check("three_pulses", 64'(pulses.size()), 64'd3);
    if (pulses.size() == 3) begin
      check("lat_load", 64'(pulses[0] - c0), 64'd2);
      check("lat_acc1", 64'(pulses[1] - pulses[0]), 64'd2);
      check("lat_acc2", 64'(pulses[2] - pulses[1]), 64'd2);
    end

    // Hold presentation while next is low; match_lines wiggles unsampled.
    push(4, 2);
    push(5, 1);
    load = 1'b1;
    match_lines = 64'h30;
    cycle();
    load = 1'b0;
    cycle();
    for (int i = 0; i < 5; i++) begin
      match_lines = 64'(i * 64'h1111);
      check("hold_idx", {57'd0, resp_valid, resp_index}, 64'h44);
      check("hold_sel", resp_select, 64'h10);
      cycle();
    end
    next = 1'b1;
    cycle();
    next = 1'b0;
    check("hold_scan", 64'(resp_valid), 64'd0);
    cycle();
    check("hold_idx5", {57'd0, resp_valid, resp_index}, 64'h45);
    next = 1'b1;
    cycle();
    next = 1'b0;
    cycle();
    check("hold_done", 64'(done), 64'd1);
    check("hold_sb", 64'(sb.size()), 64'd0);

    // Load arriving together with next wins.
    load = 1'b1;
    match_lines = 64'hF;
    cycle();
    load = 1'b0;
    cycle();
    check("pre_idx", {57'd0, resp_valid, resp_index}, 64'h40);
    check("pre_cnt", 64'(resp_count), 64'd4);
    push(8, 1);
    load = 1'b1;
    next = 1'b1;
    match_lines = 64'h100;
    cycle();
    load = 1'b0;
    next = 1'b0;
    check("relo_cnt", 64'(resp_count), 64'd1);
    check("relo_scan", 64'(resp_valid), 64'd0);
    cycle();
    check("relo_idx", {57'd0, resp_valid, resp_index}, 64'h48);
    next = 1'b1;
    cycle();
    next = 1'b0;
    cycle();
    check("relo_done", 64'(done), 64'd1);
    check("relo_sb", 64'(sb.size()), 64'd0);

    // clear beats next while presenting.
    load = 1'b1;
    match_lines = 64'hFF;
    cycle();
    load = 1'b0;
    cycle();
    check("clr_pre", {57'd0, resp_valid, resp_index}, 64'h40);
    check("clr_some", 64'(some_responder), 64'd1);
    clear = 1'b1;
    next = 1'b1;
    cycle();
    clear = 1'b0;
    next = 1'b0;
    check("clr_outs", outs(), 64'd0);
    check("clr_sel", resp_select, 64'd0);
    cycle();
    check("clr_idle", outs(), 64'd0);

    // Async reset between edges.
    load = 1'b1;
    match_lines = 64'hFF;
    cycle();
    load = 1'b0;
    cycle();
    check("rst2_pre", {57'd0, resp_valid, resp_index}, 64'h40);
    #2;
    rst = 1'b1;
    #1;
    check("rst2_outs", outs(), 64'd0);
    check("rst2_sel", resp_select, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    next = 1'b1;
    cycle();
    cycle();
    next = 1'b0;
    check("rst2_idle", outs(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
